// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of a single regfile write port: buffers (addr, data) entries in a
// circular FIFO, drains them in order, and forwards the youngest pending value to two readers.
module regfile_wb_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AWIDTH-1:0]          in_addr,
  input  logic [DWIDTH-1:0]          in_data,
  input  logic                       drain_en,
  output logic                       rf_we,
  output logic [AWIDTH-1:0]          rf_wa,
  output logic [DWIDTH-1:0]          rf_wd,
  input  logic [AWIDTH-1:0]          byp_addr1,
  input  logic [AWIDTH-1:0]          byp_addr2,
  output logic                       byp_hit1,
  output logic                       byp_hit2,
  output logic [DWIDTH-1:0]          byp_data1,
  output logic [DWIDTH-1:0]          byp_data2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AWIDTH-1:0] addr_q [DEPTH];
  logic [DWIDTH-1:0] data_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic push, pop;
  logic not_empty;

  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q != CW'(DEPTH));
  // Writes to r0 are architecturally dead, so they are accepted but never stored.
  assign push      = in_valid && in_ready && (in_addr != '0);
  assign pop       = not_empty && drain_en;

  assign rf_we = pop;
  assign rf_wa = not_empty ? addr_q[head_q] : '0;
  assign rf_wd = not_empty ? data_q[head_q] : '0;
  assign count = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (push) begin
      tail_d = tail_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is left unreset; the occupancy count masks stale slots.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
    end
  end

  // Scan oldest to youngest so the last match, the youngest, wins.
  function automatic logic [DWIDTH:0] lookup(input logic [AWIDTH-1:0] raddr);
    logic [DWIDTH:0] res;
    logic [PW-1:0]   idx;
    res = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (raddr != '0) && (addr_q[idx] == raddr)) begin
        res = {1'b1, data_q[idx]};
      end
    end
    return res;
  endfunction

  always_comb begin
    {byp_hit1, byp_data1} = lookup(byp_addr1);
    {byp_hit2, byp_data2} = lookup(byp_addr2);
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: directed vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic          drain_en = 1'b0;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [AW-1:0] byp_addr1 = '0;
  logic [AW-1:0] byp_addr2 = '0;
  logic          byp_hit1, byp_hit2;
  logic [DW-1:0] byp_data1, byp_data2;
  logic [CW-1:0] count;

  regfile_wb_queue #(.DEPTH(DEPTH), .DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .drain_en  (drain_en),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .byp_addr1 (byp_addr1),
    .byp_addr2 (byp_addr2),
    .byp_hit1  (byp_hit1),
    .byp_hit2  (byp_hit2),
    .byp_data1 (byp_data1),
    .byp_data2 (byp_data2),
    .count     (count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending writes, oldest at index 0.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;
  ent_t mq[$];

  task automatic model_check(input string tag);
    logic          e_h1, e_h2;
    logic [DW-1:0] e_d1, e_d2;
    e_h1 = 1'b0; e_d1 = '0; e_h2 = 1'b0; e_d2 = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!e_h1 && byp_addr1 != 0 && mq[i].a == byp_addr1) begin e_h1 = 1'b1; e_d1 = mq[i].d; end
      if (!e_h2 && byp_addr2 != 0 && mq[i].a == byp_addr2) begin e_h2 = 1'b1; e_d2 = mq[i].d; end
    end
    chk({tag, ".count"}, 64'(count), 64'(mq.size()));
    chk({tag, ".ready"}, 64'(in_ready), 64'(mq.size() != DEPTH));
    chk({tag, ".we"}, 64'(rf_we), 64'(mq.size() != 0 && drain_en));
    chk({tag, ".wa"}, 64'(rf_wa), mq.size() != 0 ? 64'(mq[0].a) : 64'(0));
    chk({tag, ".wd"}, 64'(rf_wd), mq.size() != 0 ? 64'(mq[0].d) : 64'(0));
    chk({tag, ".hit1"}, 64'(byp_hit1), 64'(e_h1));
    chk({tag, ".data1"}, 64'(byp_data1), 64'(e_d1));
    chk({tag, ".hit2"}, 64'(byp_hit2), 64'(e_h2));
    chk({tag, ".data2"}, 64'(byp_data2), 64'(e_d2));
  endtask

  // One clock: drive at negedge, check before the edge, then advance the model on the edge.
  task automatic step(input string tag, input logic v, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic dr,
                      input logic [AW-1:0] b1, input logic [AW-1:0] b2);
    bit do_pop, do_push;
    ent_t e;
    @(negedge clk);
    in_valid = v; in_addr = a; in_data = d; drain_en = dr; byp_addr1 = b1; byp_addr2 = b2;
    #1;
    model_check(tag);
    do_pop  = (mq.size() != 0) && dr;
    do_push = v && (mq.size() != DEPTH) && (a != 0);
    @(posedge clk);
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      e.a = a; e.d = d;
      mq.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0; in_addr = '0; in_data = '0; drain_en = 1'b1;
    byp_addr1 = '0; byp_addr2 = '0;
    mq.delete();
    #1;
    chk("rst.count", 64'(count), 64'(0));
    chk("rst.ready", 64'(in_ready), 64'(1));
    chk("rst.we", 64'(rf_we), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    drain_en = 1'b0;
  endtask

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          dr;
    logic [AW-1:0] b1, b2;
    int            cnt;
    logic          rdy, we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          h1;
    logic [DW-1:0] d1;
    logic          h2;
    logic [DW-1:0] d2;
  } vec_t;

  vec_t tv[9];

  initial begin
    // Expected outputs are sampled before the edge that applies each row's inputs.
    tv[0] = '{1'b1, 5'd3, 32'hAAAA0001, 1'b0, 5'd3, 5'd0, 0, 1'b1, 1'b0, 5'd0, 32'h0,
              1'b0, 32'h0, 1'b0, 32'h0};
    tv[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd5, 1, 1'b1, 1'b0, 5'd3, 32'hAAAA0001,
              1'b1, 32'hAAAA0001, 1'b0, 32'h0};
    tv[2] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 1, 1'b1, 1'b1, 5'd3, 32'hAAAA0001,
              1'b1, 32'hAAAA0001, 1'b0, 32'h0};
    tv[3] = '{1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 5'd5, 0, 1'b1, 1'b0, 5'd0, 32'h0,
              1'b0, 32'h0, 1'b0, 32'h0};
    tv[4] = '{1'b1, 5'd5, 32'h22, 1'b0, 5'd0, 5'd5, 1, 1'b1, 1'b0, 5'd5, 32'h11,
              1'b0, 32'h0, 1'b1, 32'h11};
    tv[5] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd5, 2, 1'b1, 1'b1, 5'd5, 32'h11,
              1'b0, 32'h0, 1'b1, 32'h22};
    tv[6] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd5, 1, 1'b1, 1'b1, 5'd5, 32'h22,
              1'b0, 32'h0, 1'b1, 32'h22};
    tv[7] = '{1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 5'd0, 0, 1'b1, 1'b0, 5'd0, 32'h0,
              1'b0, 32'h0, 1'b0, 32'h0};
    tv[8] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd5, 0, 1'b1, 1'b0, 5'd0, 32'h0,
              1'b0, 32'h0, 1'b0, 32'h0};

    do_reset();

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = tv[i].v; in_addr = tv[i].a; in_data = tv[i].d; drain_en = tv[i].dr;
      byp_addr1 = tv[i].b1; byp_addr2 = tv[i].b2;
      #1;
      chk($sformatf("vec%0d.count", i), 64'(count), 64'(tv[i].cnt));
      chk($sformatf("vec%0d.ready", i), 64'(in_ready), 64'(tv[i].rdy));
      chk($sformatf("vec%0d.we", i), 64'(rf_we), 64'(tv[i].we));
      chk($sformatf("vec%0d.wa", i), 64'(rf_wa), 64'(tv[i].wa));
      chk($sformatf("vec%0d.wd", i), 64'(rf_wd), 64'(tv[i].wd));
      chk($sformatf("vec%0d.hit1", i), 64'(byp_hit1), 64'(tv[i].h1));
      chk($sformatf("vec%0d.data1", i), 64'(byp_data1), 64'(tv[i].d1));
      chk($sformatf("vec%0d.hit2", i), 64'(byp_hit2), 64'(tv[i].h2));
      chk($sformatf("vec%0d.data2", i), 64'(byp_data2), 64'(tv[i].d2));
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    chk("vec.final_count", 64'(count), 64'(0));

    // Full queue: pushes blocked, then a held push with drain gives one pop only.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step("fill", 1'b1, AW'(i + 1), DW'(32'h100 + i), 1'b0, AW'(i + 1), 5'd1);
    end
    step("full_hold", 1'b1, 5'd9, 32'hBEEF, 1'b1, 5'd9, 5'd1);
    @(negedge clk);
    #1;
    chk("full.count_after", 64'(count), 64'(DEPTH - 1));
    chk("full.ready_after", 64'(in_ready), 64'(1));
    chk("full.no_push_hit", 64'(byp_hit1), 64'(0));

    // Streaming push+drain across several pointer wraps.
    do_reset();
    step("pre", 1'b1, 5'd7, 32'h7000, 1'b0, 5'd7, 5'd0);
    step("pre", 1'b1, 5'd8, 32'h8000, 1'b0, 5'd7, 5'd8);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      step("stream", 1'b1, AW'(1 + (i % 3)), DW'(32'h5000 + i), 1'b1, AW'(1 + (i % 3)), 5'd8);
    end
    @(negedge clk);
    #1;
    chk("stream.count", 64'(count), 64'(2));

    // Asynchronous reset between edges with three entries pending.
    do_reset();
    step("ar", 1'b1, 5'd2, 32'h2, 1'b0, 5'd2, 5'd3);
    step("ar", 1'b1, 5'd3, 32'h3, 1'b0, 5'd2, 5'd3);
    step("ar", 1'b1, 5'd4, 32'h4, 1'b0, 5'd2, 5'd3);
    @(negedge clk);
    in_valid = 1'b0; drain_en = 1'b1; byp_addr1 = 5'd2; byp_addr2 = 5'd4;
    #1;
    chk("ar.count_before", 64'(count), 64'(3));
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar.count", 64'(count), 64'(0));
    chk("ar.we", 64'(rf_we), 64'(0));
    chk("ar.wa", 64'(rf_wa), 64'(0));
    chk("ar.hit1", 64'(byp_hit1), 64'(0));
    chk("ar.hit2", 64'(byp_hit2), 64'(0));
    chk("ar.ready", 64'(in_ready), 64'(1));
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drain_en = 1'b0;

    // Randomized traffic against the model; small address space forces bypass collisions.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 4)), DW'($urandom),
           1'($urandom_range(0, 2) == 0 ? 1 : $urandom_range(0, 1)),
           AW'($urandom_range(0, 4)), AW'($urandom_range(0, 4)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
